// File: rtl/turn_sequencer.sv
// turn_sequencer: runs one battle turn. It orders the attackers by speed,
// takes each hit from the shared damage calculator, drains the defender's HP
// through the HP register write port, and waits for ENTER after each "X used Y"
// message.
// Build option: define HP_DRAIN_ANIM_EN to drain HP one point per tick pulse.
// Without it, the whole hit is written in a single HP register write.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_turn
// ORDER  | latch who attacks first (a speed tie goes to the enemy)
// CALC1  | first attacker selected on the calculator, capped hit latched
// DRAIN1 | writing the first hit into the defender's HP
// MSG1   | first attacker's message shown, wait for an ENTER press
// CALC2  | roles swapped, capped hit latched
// DRAIN2 | writing the second hit into the defender's HP
// MSG2   | second attacker's message shown, wait for an ENTER press
// DONE   | pulse turn_done with the faint flags

module turn_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start_turn,
    input  logic [7:0] player_speed,
    input  logic [7:0] enemy_speed,
    input  logic [7:0] player_hp,
    input  logic [7:0] enemy_hp,
    input  logic [7:0] damage,
    input  logic       key_enter,
    input  logic       tick,
    output logic       is_player,
    output logic       hp_we,
    output logic       hp_target,
    output logic [7:0] hp_wdata,
    output logic       show_player_msg,
    output logic       show_enemy_msg,
    output logic       busy,
    output logic       turn_done,
    output logic       faint_player,
    output logic       faint_enemy
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_ORDER  = 4'd1;
    localparam logic [3:0] ST_CALC1  = 4'd2;
    localparam logic [3:0] ST_DRAIN1 = 4'd3;
    localparam logic [3:0] ST_MSG1   = 4'd4;
    localparam logic [3:0] ST_CALC2  = 4'd5;
    localparam logic [3:0] ST_DRAIN2 = 4'd6;
    localparam logic [3:0] ST_MSG2   = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    logic [3:0] state_q, state_d;
    logic       first_q, first_d;        // 1 = player attacks first
    logic [7:0] rem_q, rem_d;            // HP points still to remove
    logic       is_player_q, is_player_d;
    logic       key_q;

    logic [7:0] def_hp;
    logic       key_rise;
    logic       in_msg;

    // The defender is always the side that is not attacking.
    assign def_hp   = is_player_q ? enemy_hp : player_hp;
    assign key_rise = key_enter & ~key_q;
    assign in_msg   = (state_q == ST_MSG1) || (state_q == ST_MSG2);

`ifndef HP_DRAIN_ANIM_EN
    logic unused_tick;
    assign unused_tick = tick;
`endif

    // Next-state logic and the HP write port / turn-end strobes.
    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        rem_d        = rem_q;
        is_player_d  = is_player_q;
        hp_we        = 1'b0;
        hp_target    = 1'b0;
        hp_wdata     = 8'h00;
        turn_done    = 1'b0;
        faint_player = 1'b0;
        faint_enemy  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_turn) begin
                    state_d = ST_ORDER;
                end
            end

            ST_ORDER: begin
                first_d     = (player_speed > enemy_speed);
                is_player_d = first_d;
                state_d     = ST_CALC1;
            end

            // Capping the hit at the defender's HP is what keeps HP from wrapping.
            ST_CALC1, ST_CALC2: begin
                rem_d   = (damage < def_hp) ? damage : def_hp;
                state_d = (state_q == ST_CALC1) ? ST_DRAIN1 : ST_DRAIN2;
            end

            ST_DRAIN1, ST_DRAIN2: begin
`ifdef HP_DRAIN_ANIM_EN
                if (rem_q == 8'd0) begin
                    state_d = (state_q == ST_DRAIN1) ? ST_MSG1 : ST_MSG2;
                end else if (tick) begin
                    hp_we     = 1'b1;
                    hp_target = is_player_q;
                    hp_wdata  = def_hp - 8'd1;
                    rem_d     = rem_q - 8'd1;
                end
`else
                if (rem_q != 8'd0) begin
                    hp_we     = 1'b1;
                    hp_target = is_player_q;
                    hp_wdata  = def_hp - rem_q;
                end
                rem_d   = 8'd0;
                state_d = (state_q == ST_DRAIN1) ? ST_MSG1 : ST_MSG2;
`endif
            end

            // A fainted defender ends the turn before it can strike back.
            ST_MSG1: begin
                if (key_rise) begin
                    if (def_hp == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_CALC2;
                        is_player_d = ~first_q;
                    end
                end
            end

            ST_MSG2: begin
                if (key_rise) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                turn_done    = 1'b1;
                faint_player = (player_hp == 8'd0);
                faint_enemy  = (enemy_hp == 8'd0);
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, turn order, remaining damage, calculator select and ENTER history.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            first_q     <= 1'b0;
            rem_q       <= 8'd0;
            is_player_q <= 1'b0;
            key_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            rem_q       <= rem_d;
            is_player_q <= is_player_d;
            key_q       <= key_enter;
        end
    end

    assign is_player       = is_player_q;
    assign busy            = (state_q != ST_IDLE);
    assign show_player_msg = in_msg & is_player_q;
    assign show_enemy_msg  = in_msg & ~is_player_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Testbench for turn_sequencer: models the HP registers and the damage
// calculator around the DUT, predicts each turn from the battle rules and
// checks the write stream, messages and faint flags.

module tb_turn_sequencer;

`ifdef HP_DRAIN_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start_turn = 1'b0;
    logic [7:0] player_speed = 8'd0;
    logic [7:0] enemy_speed = 8'd0;
    logic [7:0] player_hp = 8'd0;
    logic [7:0] enemy_hp = 8'd0;
    logic [7:0] damage;
    logic       key_enter = 1'b0;
    logic       tick = 1'b0;
    logic       is_player, hp_we, hp_target;
    logic [7:0] hp_wdata;
    logic       show_player_msg, show_enemy_msg, busy, turn_done;
    logic       faint_player, faint_enemy;

    logic [7:0] dmg_p = 8'd0;
    logic [7:0] dmg_e = 8'd0;
    logic       hp_load = 1'b0;
    logic [7:0] load_p = 8'd0;
    logic [7:0] load_e = 8'd0;

    typedef struct packed {
        logic       tgt;
        logic [7:0] data;
    } wr_t;

    wr_t exp_wr[$];
    bit  exp_atk[$];
    bit  exp_fp, exp_fe;
    int  errors = 0;
    int  checks = 0;

    logic [16:0] all_outs;
    assign all_outs = {is_player, hp_we, hp_target, hp_wdata, show_player_msg,
                       show_enemy_msg, busy, turn_done, faint_player, faint_enemy};

    turn_sequencer dut (
        .Clk(Clk), .Reset(Reset), .start_turn(start_turn),
        .player_speed(player_speed), .enemy_speed(enemy_speed),
        .player_hp(player_hp), .enemy_hp(enemy_hp), .damage(damage),
        .key_enter(key_enter), .tick(tick), .is_player(is_player),
        .hp_we(hp_we), .hp_target(hp_target), .hp_wdata(hp_wdata),
        .show_player_msg(show_player_msg), .show_enemy_msg(show_enemy_msg),
        .busy(busy), .turn_done(turn_done),
        .faint_player(faint_player), .faint_enemy(faint_enemy)
    );

    always #5 Clk = ~Clk;

    // Damage calculator: each side has a fixed hit for the current scenario.
    assign damage = is_player ? dmg_p : dmg_e;

    // HP registers; committed writes survive a sequencer reset.
    always @(posedge Clk) begin
        if (hp_load) begin
            player_hp <= load_p;
            enemy_hp  <= load_e;
        end else if (hp_we) begin
            if (hp_target) enemy_hp <= hp_wdata;
            else           player_hp <= hp_wdata;
        end
    end

    task automatic load_hp(input logic [7:0] p, input logic [7:0] e);
        @(negedge Clk);
        load_p  = p;
        load_e  = e;
        hp_load = 1'b1;
        @(negedge Clk);
        hp_load = 1'b0;
    endtask

    // Reference model: who attacks, which writes land, who faints.
    task automatic plan_turn(input logic [7:0] ps, input logic [7:0] es,
                             input logic [7:0] dp, input logic [7:0] de);
        int  hp [2];
        bit  atk;
        int  def, d, cap;
        wr_t w;
        player_speed = ps;
        enemy_speed  = es;
        dmg_p        = dp;
        dmg_e        = de;
        exp_wr.delete();
        exp_atk.delete();
        hp[0] = int'(player_hp);
        hp[1] = int'(enemy_hp);
        for (int a = 0; a < 2; a++) begin
            atk = (a == 0) ? (ps > es) : !(ps > es);
            def = atk ? 1 : 0;
            d   = atk ? int'(dp) : int'(de);
            cap = (d < hp[def]) ? d : hp[def];
            w.tgt = (def == 1);
            if (ANIM) begin
                for (int i = 1; i <= cap; i++) begin
                    w.data = 8'(hp[def] - i);
                    exp_wr.push_back(w);
                end
            end else if (cap > 0) begin
                w.data = 8'(hp[def] - cap);
                exp_wr.push_back(w);
            end
            hp[def] = hp[def] - cap;
            exp_atk.push_back(atk);
            if (hp[def] == 0) break;
        end
        exp_fp = (hp[0] == 0);
        exp_fe = (hp[1] == 0);
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start_turn = 1'b1;
        @(negedge Clk);
        start_turn = 1'b0;
    endtask

    // Follows one turn to turn_done, checking every write, message and the end flags.
    task automatic monitor_turn(input string name, input int hold_cycles, input bit spam_start);
        bit  done_seen = 0;
        bit  prev_show = 0;
        bit  cur_show;
        bit  first_msg = 1;
        bit  just_pressed = 0;
        bit  held_ok = 1;
        int  key_wait = 0;
        int  hold = 0;
        bit  a;
        wr_t w;
        for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
            @(negedge Clk);
            if (just_pressed) begin
                checks++;
                if (show_player_msg || show_enemy_msg) begin
                    errors++;
                    $display("FAIL %s enter_advance: msg still shown after press", name);
                end
                just_pressed = 0;
            end
            if (hp_we) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL %s write: unexpected tgt=%0d data=%0d", name, hp_target, hp_wdata);
                end else begin
                    w = exp_wr.pop_front();
                    if ({hp_target, hp_wdata} !== {w.tgt, w.data} || (ANIM && !tick)) begin
                        errors++;
                        $display("FAIL %s write: got tgt=%0d data=%0d tick=%0d, want tgt=%0d data=%0d",
                                 name, hp_target, hp_wdata, tick, w.tgt, w.data);
                    end
                end
            end
            cur_show = show_player_msg | show_enemy_msg;
            if (cur_show && !prev_show) begin
                checks++;
                if (exp_atk.size() == 0) begin
                    errors++;
                    $display("FAIL %s msg: unexpected message p=%0d e=%0d", name, show_player_msg, show_enemy_msg);
                end else begin
                    a = exp_atk.pop_front();
                    if ({show_player_msg, show_enemy_msg, is_player} !== {a, !a, a}) begin
                        errors++;
                        $display("FAIL %s msg: got p=%0d e=%0d is_player=%0d, want attacker player=%0d",
                                 name, show_player_msg, show_enemy_msg, is_player, a);
                    end
                end
                if (first_msg && hold_cycles > 0) hold = hold_cycles;
                else key_wait = 2;
                first_msg = 0;
            end
            prev_show = cur_show;
            if (turn_done) begin
                checks++;
                if ({faint_player, faint_enemy} !== {exp_fp, exp_fe} || exp_wr.size() != 0 || exp_atk.size() != 0) begin
                    errors++;
                    $display("FAIL %s done: faint p/e=%0d/%0d want %0d/%0d, writes left=%0d msgs left=%0d",
                             name, faint_player, faint_enemy, exp_fp, exp_fe, exp_wr.size(), exp_atk.size());
                end
                done_seen = 1;
            end
            tick = ANIM ? ($urandom_range(0, 2) == 0) : 1'($urandom);
            start_turn = (spam_start && busy && !done_seen) ? 1'($urandom) : 1'b0;
            if (hold > 0) begin
                if (!cur_show) held_ok = 0;
                hold--;
                key_enter = 1'b1;
                if (hold == 0) begin
                    checks++;
                    if (!held_ok) begin
                        errors++;
                        $display("FAIL %s enter_held: advanced while ENTER held, want stay in message", name);
                    end
                    key_wait = 2;
                end
            end else if (key_wait == 2) begin
                key_enter = 1'b0;
                key_wait  = 1;
            end else if (key_wait == 1) begin
                key_enter    = 1'b1;
                key_wait     = 0;
                just_pressed = 1;
            end else begin
                key_enter = (hold_cycles > 0 && first_msg) ? 1'b1 : 1'b0;
            end
        end
        key_enter  = 1'b0;
        start_turn = 1'b0;
        tick       = 1'b0;
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s timeout: turn_done=0, want a turn_done pulse", name);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (all_outs !== 17'd0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h want 0", all_outs);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (all_outs !== 17'd0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h want 0", all_outs);
        end
    endtask

    task automatic test_turn(input string name, input logic [7:0] php, input logic [7:0] ehp,
                             input logic [7:0] ps, input logic [7:0] es,
                             input logic [7:0] dp, input logic [7:0] de, input int hold);
        load_hp(php, ehp);
        plan_turn(ps, es, dp, de);
        if (hold > 0) key_enter = 1'b1;
        pulse_start();
        monitor_turn(name, hold, 1'b0);
    endtask

    task automatic test_busy_ignore();
        bit idle_ok = 1;
        load_hp(8'd20, 8'd20);
        plan_turn(8'd10, 8'd90, 8'd2, 8'd7);
        pulse_start();
        monitor_turn("busy_ignore", 0, 1'b1);
        repeat (5) begin
            @(negedge Clk);
            if (busy || hp_we) idle_ok = 0;
        end
        checks++;
        if (!idle_ok) begin
            errors++;
            $display("FAIL busy_ignore idle: busy after turn, want idle (start while busy ignored)");
        end
    endtask

    task automatic test_reset_mid_drain();
        int n_before = 0;
        bit found = 0;
        bit quiet = 1;
        load_hp(8'd30, 8'd30);
        plan_turn(8'd50, 8'd40, 8'd5, 8'd5);
        pulse_start();
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge Clk);
            if (hp_we) begin
                if (!ANIM || n_before >= 2) found = 1;
                else n_before++;
            end
            if (!found) tick = ANIM ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_drain timeout: no hp_we seen, want a drain write");
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (all_outs !== 17'd0) begin
            errors++;
            $display("FAIL mid_drain async: outputs=%h want 0", all_outs);
        end
        tick = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (hp_we || busy) quiet = 0;
        end
        Reset = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            if (hp_we || busy) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL mid_drain quiet: activity after reset, want idle with no hp_we");
        end
        checks++;
        if (enemy_hp !== 8'(30 - n_before) || player_hp !== 8'd30) begin
            errors++;
            $display("FAIL mid_drain hp: got p=%0d e=%0d want p=30 e=%0d", player_hp, enemy_hp, 30 - n_before);
        end
        plan_turn(8'd50, 8'd40, 8'd5, 8'd5);
        pulse_start();
        monitor_turn("after_reset", 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] ps, es;
        for (int t = 0; t < 10; t++) begin
            ps = 8'($urandom_range(0, 255));
            es = (t % 3 == 0) ? ps : 8'($urandom_range(0, 255));
            test_turn("random", 8'($urandom_range(1, 70)), 8'($urandom_range(1, 70)), ps, es,
                      8'($urandom_range(0, 45)), 8'($urandom_range(0, 45)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_turn("basic", 8'd20, 8'd20, 8'd50, 8'd40, 8'd3, 8'd3, 0);
        test_turn("tie", 8'd20, 8'd20, 8'd40, 8'd40, 8'd4, 8'd6, 0);
        test_turn("faint", 8'd25, 8'd10, 8'd60, 8'd10, 8'd30, 8'd9, 0);
        test_turn("enter_held", 8'd40, 8'd40, 8'd30, 8'd20, 8'd5, 8'd5, 100);
        test_busy_ignore();
        test_reset_mid_drain();
        test_turn("zero_damage", 8'd15, 8'd15, 8'd5, 8'd9, 8'd0, 8'd0, 0);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
